// File: rtl/serial_addsub_4bit.sv
// Bit-serial adder/subtractor: processes one bit per cycle, LSB first, and publishes
// sum/Cout/ovf with a one-cycle done pulse once all WIDTH bits have been consumed.
module serial_addsub_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             c_q, c_d;
  logic             cmsb_q, cmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             b_eff;
  logic             bit_res;
  logic             last_bit;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    c_d      = c_q;
    cmsb_d   = cmsb_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    // Subtract inverts b; the +1 comes from the carry being preset to sel at capture.
    b_eff    = b_sh_q[0] ^ sel_q;
    bit_res  = a_sh_q[0] ^ b_eff ^ c_q;
    last_bit = (cnt_q == CntW'(WIDTH - 1));

    case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          sel_d   = sel;
          c_d     = sel;
          cnt_d   = '0;
          res_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d  = {bit_res, res_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = (a_sh_q[0] & b_eff) | (a_sh_q[0] & c_q) | (b_eff & c_q);
        cnt_d  = cnt_q + CntW'(1);
        if (last_bit) begin
          cmsb_d  = c_q;
          state_d = StDone;
        end
      end
      StDone: begin
        sum_d   = res_q;
        cout_d  = c_q;
        ovf_d   = cmsb_q ^ c_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      c_q     <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      c_q     <= c_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_addsub_4bit.sv
// Directed bench for serial_addsub_4bit (WIDTH=4): arithmetic vectors, latency,
// issue interval, start-ignore and mid-run reset behaviour.
module tb_serial_addsub_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sel;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sum;
  logic       Cout;
  logic       ovf;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  serial_addsub_4bit #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sel  (sel),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .Cout (Cout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation, scrambles inputs after capture, and checks latency and results.
  task automatic run_op(input string tag, input logic s, input logic [3:0] av,
                        input logic [3:0] bv, input logic [3:0] es, input logic ec,
                        input logic eo);
    int   k;
    logic seen;
    @(negedge clk);
    sel = s; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; sel = ~s;
    check({tag, " busy"}, 32'(busy), 32'd1);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(k), 32'd5);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " Cout"}, 32'(Cout), 32'(ec));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    check({tag, " done pulse width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int k;
    int n_done;
    logic seen;

    rst = 1'b1; start = 1'b0; sel = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset sum", 32'(sum), 32'd0);
    check("reset Cout", 32'(Cout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b0;

    run_op("add 3+4", 1'b0, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0);
    run_op("add 15+1", 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0);
    run_op("add 7+1", 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1);
    run_op("sub 5-3", 1'b1, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0);
    run_op("sub 3-5", 1'b1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0);
    run_op("sub -8-1", 1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1);

    // Results hold while idle and inputs move.
    a = 4'b1010; b = 4'b0101; sel = 1'b0;
    repeat (4) @(negedge clk);
    check("hold sum", 32'(sum), 32'd7);
    check("hold Cout", 32'(Cout), 32'd1);
    check("hold ovf", 32'(ovf), 32'd1);
    check("hold done", 32'(done), 32'd0);

    // Start held high: one operation every WIDTH+2 cycles.
    sel = 1'b0; a = 4'd1; b = 4'd2; start = 1'b1;
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    check("held first done", 32'(seen), 32'd1);
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("held interval", 32'(k), 32'd6);
    check("held sum", 32'(sum), 32'd3);
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("held no extra op", 32'(n_done), 32'd0);
    check("held idle busy", 32'(busy), 32'd0);

    // Start pulsed during RUN is ignored.
    @(negedge clk);
    sel = 1'b0; a = 4'd2; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd9; b = 4'd3; sel = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        check("ignore-start sum", 32'(sum), 32'd4);
      end
    end
    check("ignore-start done count", 32'(n_done), 32'd1);

    // Reset at RUN cycle 2 aborts the operation.
    sel = 1'b0; a = 4'd5; b = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort sum", 32'(sum), 32'd0);
    check("abort Cout", 32'(Cout), 32'd0);
    check("abort ovf", 32'(ovf), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no done", 32'(n_done), 32'd0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst over start busy", 32'(busy), 32'd0);

    run_op("post-reset add 3+4", 1'b0, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
